regfile_sb: RTL and testbench

Parametrised successor of the core register file, with two write ports: W0 for ALU writeback and W1 for load writeback. Adds a per-register scoreboard that tracks outstanding loads and stalls operand fetch until the data returns. Provides same-cycle write-to-read bypass, an optional hardwired zero register, and a configurable link register. Sits between the decode/fetch stage and the writeback/LSU stages.

---
 rtl/regfile_pkg.sv | 33 +++
 rtl/regfile_sb_if.sv | 62 ++++++
 rtl/regfile_scoreboard.sv | 73 +++++++
 rtl/regfile_sb.sv | 123 ++++++++++++
 tb/tb_regfile_sb.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the scoreboarded register file.
//   DATA_SIZE_DEFAULT / ADDR_SIZE_DEFAULT : default data and address widths
//   LINK_REG_DEFAULT                      : register written by jump-and-link
//   wsrc_e                                : which write port owns a register
//   pickSource()                          : resolves same-address collisions
// ---------------------------------------------------------------------------
package regfile_pkg;

   localparam int DATA_SIZE_DEFAULT = 32;
   localparam int ADDR_SIZE_DEFAULT = 5;
   localparam int LINK_REG_DEFAULT  = 30;

   typedef enum logic [1:0] {
      WSRC_NONE,
      WSRC_LINK,
      WSRC_LOAD,
      WSRC_ALU
   } wsrc_e;

   // When several ports hit the same register in one cycle the link write
   // beats the load return, which beats the ALU writeback.
   function automatic wsrc_e pickSource(input logic linkHit,
                                        input logic loadHit,
                                        input logic aluHit);
      if (linkHit)      return WSRC_LINK;
      else if (loadHit) return WSRC_LOAD;
      else if (aluHit)  return WSRC_ALU;
      else              return WSRC_NONE;
   endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if
// Bundle of every pipeline-facing signal of the register file.
//   master : decode/fetch + writeback + LSU side (drives requests)
//   slave  : register file side (drives operands, stall and issue-ready)
// Fetch      : enable_reg_fetch, reg_{ra,rb,rt}_addr -> reg_{ra,rb,rt}_data, fetch_stall
// W0 (ALU)   : enable_reg_write, do_reg_write, write_reg_addr, write_reg_data
// Load issue : load_issue_valid, load_issue_addr -> load_issue_ready
// W1 (load)  : load_wb_valid, load_wb_addr, load_wb_data
// Link       : do_jump_link, current_pc
// ---------------------------------------------------------------------------
interface regfile_sb_if #(
   parameter int DataSize = 32,
   parameter int AddrSize = 5
);

   logic                enable_reg_fetch;
   logic [AddrSize-1:0] reg_ra_addr;
   logic [AddrSize-1:0] reg_rb_addr;
   logic [AddrSize-1:0] reg_rt_addr;
   logic [DataSize-1:0] reg_ra_data;
   logic [DataSize-1:0] reg_rb_data;
   logic [DataSize-1:0] reg_rt_data;
   logic                fetch_stall;

   logic                enable_reg_write;
   logic                do_reg_write;
   logic [AddrSize-1:0] write_reg_addr;
   logic [DataSize-1:0] write_reg_data;

   logic                load_issue_valid;
   logic [AddrSize-1:0] load_issue_addr;
   logic                load_issue_ready;

   logic                load_wb_valid;
   logic [AddrSize-1:0] load_wb_addr;
   logic [DataSize-1:0] load_wb_data;

   logic                do_jump_link;
   logic [31:0]         current_pc;

   modport master (
      output enable_reg_fetch, reg_ra_addr, reg_rb_addr, reg_rt_addr,
      input  reg_ra_data, reg_rb_data, reg_rt_data, fetch_stall,
      output enable_reg_write, do_reg_write, write_reg_addr, write_reg_data,
      output load_issue_valid, load_issue_addr,
      input  load_issue_ready,
      output load_wb_valid, load_wb_addr, load_wb_data,
      output do_jump_link, current_pc
   );

   modport slave (
      input  enable_reg_fetch, reg_ra_addr, reg_rb_addr, reg_rt_addr,
      output reg_ra_data, reg_rb_data, reg_rt_data, fetch_stall,
      input  enable_reg_write, do_reg_write, write_reg_addr, write_reg_data,
      input  load_issue_valid, load_issue_addr,
      output load_issue_ready,
      input  load_wb_valid, load_wb_addr, load_wb_data,
      input  do_jump_link, current_pc
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// One busy bit per register marking an outstanding load.
//   clock, reset (async, active-high)
//   enable_reg_fetch_i, ra/rb/rt_addr_i : operand fetch request and sources
//   load_issue_valid_i, load_issue_addr_i : load issue (sets busy)
//   load_wb_valid_i, load_wb_addr_i       : load return (clears busy)
//   fetch_stall_o      : a source is busy and not being returned this cycle
//   load_issue_ready_o : destination of the issue is free
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
   parameter int AddrSize      = 5,
   parameter bit ZeroHardwired = 1'b0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable_reg_fetch_i,
   input  logic [AddrSize-1:0] ra_addr_i,
   input  logic [AddrSize-1:0] rb_addr_i,
   input  logic [AddrSize-1:0] rt_addr_i,
   input  logic                load_issue_valid_i,
   input  logic [AddrSize-1:0] load_issue_addr_i,
   input  logic                load_wb_valid_i,
   input  logic [AddrSize-1:0] load_wb_addr_i,
   output logic                fetch_stall_o,
   output logic                load_issue_ready_o
);

   localparam int RegNum = 2 ** AddrSize;

   logic [RegNum-1:0] busy_q;
   logic [RegNum-1:0] busy_d;

   // A source only blocks the fetch if its data is not arriving right now;
   // a returning load is bypassed into the operand capture instead.
   function automatic logic srcBlocked(input logic [AddrSize-1:0] addr);
      return busy_q[addr] && !(load_wb_valid_i && (load_wb_addr_i == addr));
   endfunction

   // Stall and issue-ready are purely combinational on the current state.
   always_comb begin
      load_issue_ready_o = !busy_q[load_issue_addr_i];
      fetch_stall_o      = enable_reg_fetch_i &&
                           (srcBlocked(ra_addr_i) ||
                            srcBlocked(rb_addr_i) ||
                            srcBlocked(rt_addr_i));
   end

   // The clear is applied before the set so that an issue and a return to the
   // same register in one cycle leave it busy for the newer load.
   always_comb begin
      busy_d = busy_q;
      if (load_wb_valid_i) begin
         busy_d[load_wb_addr_i] = 1'b0;
      end
      if (load_issue_valid_i && load_issue_ready_o) begin
         busy_d[load_issue_addr_i] = 1'b1;
      end
      if (ZeroHardwired) begin
         busy_d[0] = 1'b0;
      end
   end

   // Busy vector state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Register file with ALU (W0) and load (W1) write ports, a link write, a
// load scoreboard and registered, write-first operand outputs.
//   clock, reset : system clock, async active-high reset
//   bus          : regfile_sb_if.slave carrying fetch, W0, W1, load issue
//                  and jump-and-link signals
// Parameters: DataSize, AddrSize, LinkReg, ZeroHardwired
// ---------------------------------------------------------------------------
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DataSize      = DATA_SIZE_DEFAULT,
   parameter int AddrSize      = ADDR_SIZE_DEFAULT,
   parameter int LinkReg       = LINK_REG_DEFAULT,
   parameter bit ZeroHardwired = 1'b0
) (
   input  logic         clock,
   input  logic         reset,
   regfile_sb_if.slave  bus
);

   localparam int RegNum = 2 ** AddrSize;

   logic [DataSize-1:0] regFile_q [RegNum];
   logic [DataSize-1:0] regFile_d [RegNum];
   logic [DataSize-1:0] raData_q, rbData_q, rtData_q;
   logic [DataSize-1:0] raData_d, rbData_d, rtData_d;
   logic [DataSize-1:0] linkData;
   logic                aluWrite;
   logic                fetchTake;

   // The PC is always 32 bits wide; fit it to the register width.
   if (DataSize > 32) begin : g_pcExtend
      assign linkData = {{(DataSize-32){1'b0}}, bus.current_pc};
   end else begin : g_pcTrunc
      assign linkData = bus.current_pc[DataSize-1:0];
   end

   regfile_scoreboard #(
      .AddrSize      (AddrSize),
      .ZeroHardwired (ZeroHardwired)
   ) u_scoreboard (
      .clock              (clock),
      .reset              (reset),
      .enable_reg_fetch_i (bus.enable_reg_fetch),
      .ra_addr_i          (bus.reg_ra_addr),
      .rb_addr_i          (bus.reg_rb_addr),
      .rt_addr_i          (bus.reg_rt_addr),
      .load_issue_valid_i (bus.load_issue_valid),
      .load_issue_addr_i  (bus.load_issue_addr),
      .load_wb_valid_i    (bus.load_wb_valid),
      .load_wb_addr_i     (bus.load_wb_addr),
      .fetch_stall_o      (bus.fetch_stall),
      .load_issue_ready_o (bus.load_issue_ready)
   );

   assign aluWrite  = bus.enable_reg_write && bus.do_reg_write;
   assign fetchTake = bus.enable_reg_fetch && !bus.fetch_stall;

   // Next contents of every register after this cycle's writes. The same
   // array feeds both the storage update and the operand bypass, so a fetch
   // always sees exactly what the array will hold after the edge.
   always_comb begin
      for (int i = 0; i < RegNum; i++) begin
         regFile_d[i] = regFile_q[i];
         if (!(ZeroHardwired && (i == 0))) begin
            case (pickSource(bus.do_jump_link && (i == LinkReg),
                             bus.load_wb_valid && (bus.load_wb_addr == AddrSize'(i)),
                             aluWrite && (bus.write_reg_addr == AddrSize'(i))))
               WSRC_LINK: regFile_d[i] = linkData;
               WSRC_LOAD: regFile_d[i] = bus.load_wb_data;
               WSRC_ALU:  regFile_d[i] = bus.write_reg_data;
               default:   regFile_d[i] = regFile_q[i];
            endcase
         end
      end
   end

   // Operand read ports; register 0 is forced to zero when hardwired even
   // though its storage is also never written.
   always_comb begin
      raData_d = regFile_d[bus.reg_ra_addr];
      rbData_d = regFile_d[bus.reg_rb_addr];
      rtData_d = regFile_d[bus.reg_rt_addr];
      if (ZeroHardwired) begin
         if (bus.reg_ra_addr == '0) raData_d = '0;
         if (bus.reg_rb_addr == '0) rbData_d = '0;
         if (bus.reg_rt_addr == '0) rtData_d = '0;
      end
   end

   // Register storage.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RegNum; i++) begin
            regFile_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < RegNum; i++) begin
            regFile_q[i] <= regFile_d[i];
         end
      end
   end

   // Operand capture: loads only on an unstalled fetch, otherwise holds.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         raData_q <= '0;
         rbData_q <= '0;
         rtData_q <= '0;
      end else if (fetchTake) begin
         raData_q <= raData_d;
         rbData_q <= rbData_d;
         rtData_q <= rtData_d;
      end
   end

   assign bus.reg_ra_data = raData_q;
   assign bus.reg_rb_data = rbData_q;
   assign bus.reg_rt_data = rtData_q;

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
// Directed, table-driven bench for regfile_sb. One instance uses a writable
// register 0, a second instance hardwires register 0 to zero.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

   logic clock;
   logic reset;

   int checks;
   int errors;

   regfile_sb_if #(.DataSize(32), .AddrSize(5)) bus  ();
   regfile_sb_if #(.DataSize(32), .AddrSize(5)) zbus ();

   regfile_sb #(
      .DataSize(32), .AddrSize(5), .LinkReg(30), .ZeroHardwired(1'b0)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   regfile_sb #(
      .DataSize(32), .AddrSize(5), .LinkReg(30), .ZeroHardwired(1'b1)
   ) zdut (
      .clock (clock),
      .reset (reset),
      .bus   (zbus.slave)
   );

   // 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One cycle of stimulus plus what must be seen: stall/ready during the
   // cycle, and the three operand outputs after the edge.
   typedef struct {
      string       name;
      int unsigned fetch, ra, rb, rt;
      int unsigned wEn, wDo, wAddr, wData;
      int unsigned issV, issAddr;
      int unsigned wbV, wbAddr, wbData;
      int unsigned jl, pc;
      int unsigned expStall, expReady;
      int unsigned expRa, expRb, expRt;
   } vec_t;

   vec_t mainVecs[25];
   vec_t zeroVecs[6];

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic driveIdle();
      bus.enable_reg_fetch  = 1'b0; zbus.enable_reg_fetch  = 1'b0;
      bus.reg_ra_addr       = '0;   zbus.reg_ra_addr       = '0;
      bus.reg_rb_addr       = '0;   zbus.reg_rb_addr       = '0;
      bus.reg_rt_addr       = '0;   zbus.reg_rt_addr       = '0;
      bus.enable_reg_write  = 1'b0; zbus.enable_reg_write  = 1'b0;
      bus.do_reg_write      = 1'b0; zbus.do_reg_write      = 1'b0;
      bus.write_reg_addr    = '0;   zbus.write_reg_addr    = '0;
      bus.write_reg_data    = '0;   zbus.write_reg_data    = '0;
      bus.load_issue_valid  = 1'b0; zbus.load_issue_valid  = 1'b0;
      bus.load_issue_addr   = '0;   zbus.load_issue_addr   = '0;
      bus.load_wb_valid     = 1'b0; zbus.load_wb_valid     = 1'b0;
      bus.load_wb_addr      = '0;   zbus.load_wb_addr      = '0;
      bus.load_wb_data      = '0;   zbus.load_wb_data      = '0;
      bus.do_jump_link      = 1'b0; zbus.do_jump_link      = 1'b0;
      bus.current_pc        = '0;   zbus.current_pc        = '0;
   endtask

   // Drive one vector onto the selected instance at the falling edge.
   task automatic applyStimulus(input vec_t v, input bit toZero);
      @(negedge clock);
      driveIdle();
      if (!toZero) begin
         bus.enable_reg_fetch = (v.fetch != 0);
         bus.reg_ra_addr      = 5'(v.ra);
         bus.reg_rb_addr      = 5'(v.rb);
         bus.reg_rt_addr      = 5'(v.rt);
         bus.enable_reg_write = (v.wEn != 0);
         bus.do_reg_write     = (v.wDo != 0);
         bus.write_reg_addr   = 5'(v.wAddr);
         bus.write_reg_data   = v.wData;
         bus.load_issue_valid = (v.issV != 0);
         bus.load_issue_addr  = 5'(v.issAddr);
         bus.load_wb_valid    = (v.wbV != 0);
         bus.load_wb_addr     = 5'(v.wbAddr);
         bus.load_wb_data     = v.wbData;
         bus.do_jump_link     = (v.jl != 0);
         bus.current_pc       = v.pc;
      end else begin
         zbus.enable_reg_fetch = (v.fetch != 0);
         zbus.reg_ra_addr      = 5'(v.ra);
         zbus.reg_rb_addr      = 5'(v.rb);
         zbus.reg_rt_addr      = 5'(v.rt);
         zbus.enable_reg_write = (v.wEn != 0);
         zbus.do_reg_write     = (v.wDo != 0);
         zbus.write_reg_addr   = 5'(v.wAddr);
         zbus.write_reg_data   = v.wData;
         zbus.load_issue_valid = (v.issV != 0);
         zbus.load_issue_addr  = 5'(v.issAddr);
         zbus.load_wb_valid    = (v.wbV != 0);
         zbus.load_wb_addr     = 5'(v.wbAddr);
         zbus.load_wb_data     = v.wbData;
         zbus.do_jump_link     = (v.jl != 0);
         zbus.current_pc       = v.pc;
      end
   endtask

   // Combinational checks mid-cycle, registered checks #1 after the edge.
   task automatic checkOutput(input vec_t v, input bit toZero);
      #1;
      if (!toZero) begin
         compare({v.name, ".stall"}, 32'(bus.fetch_stall), v.expStall);
         compare({v.name, ".ready"}, 32'(bus.load_issue_ready), v.expReady);
      end else begin
         compare({v.name, ".stall"}, 32'(zbus.fetch_stall), v.expStall);
         compare({v.name, ".ready"}, 32'(zbus.load_issue_ready), v.expReady);
      end
      @(posedge clock);
      #1;
      if (!toZero) begin
         compare({v.name, ".ra"}, bus.reg_ra_data, v.expRa);
         compare({v.name, ".rb"}, bus.reg_rb_data, v.expRb);
         compare({v.name, ".rt"}, bus.reg_rt_data, v.expRt);
      end else begin
         compare({v.name, ".ra"}, zbus.reg_ra_data, v.expRa);
         compare({v.name, ".rb"}, zbus.reg_rb_data, v.expRb);
         compare({v.name, ".rt"}, zbus.reg_rt_data, v.expRt);
      end
   endtask

   initial begin
      vec_t v;
      checks = 0;
      errors = 0;

      //            name                 f  ra rb rt  en do wa wd            iv ia  bv ba bd          jl pc        st rd  expRa         expRb         expRt
      mainVecs[0]  = '{"bypass_w0",        1, 7, 0, 0, 1,1, 7,32'hDEADBEEF, 0, 0, 0, 0,0,           0,0,        0,1, 32'hDEADBEEF,0,            0};
      mainVecs[1]  = '{"w0_reg3",          0, 0, 0, 0, 1,1, 3,32'h55,       0, 0, 0, 0,0,           0,0,        0,1, 32'hDEADBEEF,0,            0};
      mainVecs[2]  = '{"w0_gated_en",      1, 3, 7, 3, 0,1, 3,32'h99,       0, 0, 0, 0,0,           0,0,        0,1, 32'h55,      32'hDEADBEEF, 32'h55};
      mainVecs[3]  = '{"w0_gated_do",      1, 3, 7, 7, 1,0, 3,32'h77,       0, 0, 0, 0,0,           0,0,        0,1, 32'h55,      32'hDEADBEEF, 32'hDEADBEEF};
      mainVecs[4]  = '{"issue9_fetch9",    1, 9, 7, 3, 0,0, 0,0,            1, 9, 0, 0,0,           0,0,        0,1, 0,           32'hDEADBEEF, 32'h55};
      mainVecs[5]  = '{"stall_rb9",        1, 3, 9, 7, 0,0, 0,0,            0, 9, 0, 0,0,           0,0,        1,0, 0,           32'hDEADBEEF, 32'h55};
      mainVecs[6]  = '{"reissue9_ignored", 1, 3, 9, 7, 0,0, 0,0,            1, 9, 0, 0,0,           0,0,        1,0, 0,           32'hDEADBEEF, 32'h55};
      mainVecs[7]  = '{"wb9_unstall",      1, 3, 9, 7, 0,0, 0,0,            0, 9, 1, 9,32'h1234,    0,0,        0,0, 32'h55,      32'h1234,     32'hDEADBEEF};
      mainVecs[8]  = '{"ready9",           0, 3, 9, 7, 0,0, 0,0,            0, 9, 0, 0,0,           0,0,        0,1, 32'h55,      32'h1234,     32'hDEADBEEF};
      mainVecs[9]  = '{"link_w1_w0_r30",   1,30, 7, 9, 1,1,30,32'h3,        0, 0, 1,30,32'h2,       1,32'h100,  0,1, 32'h100,     32'hDEADBEEF, 32'h1234};
      mainVecs[10] = '{"link_w1_w0_split", 1,30,12,13, 1,1,13,32'h13,       0, 0, 1,12,32'hABC,     1,32'h200,  0,1, 32'h200,     32'hABC,      32'h13};
      mainVecs[11] = '{"w1_over_w0",       1,14,30, 0, 1,1,14,32'h33,       0, 0, 1,14,32'h44,      0,0,        0,1, 32'h44,      32'h200,      0};
      mainVecs[12] = '{"w0_reg0_writable", 1, 0,14,12, 1,1, 0,32'hFFFF,     0, 0, 0, 0,0,           0,0,        0,1, 32'hFFFF,    32'h44,       32'hABC};
      mainVecs[13] = '{"issue_wb_same20",  0, 0, 0, 0, 0,0, 0,0,            1,20, 1,20,32'h20,      0,0,        0,1, 32'hFFFF,    32'h44,       32'hABC};
      mainVecs[14] = '{"stall_rt20",       1, 0, 0,20, 0,0, 0,0,            0,20, 0, 0,0,           0,0,        1,0, 32'hFFFF,    32'h44,       32'hABC};
      mainVecs[15] = '{"wb20_unstall",     1, 0, 0,20, 0,0, 0,0,            0,20, 1,20,32'h21,      0,0,        0,0, 32'hFFFF,    32'hFFFF,     32'h21};
      mainVecs[16] = '{"issue4",           0, 0, 0, 0, 0,0, 0,0,            1, 4, 0, 0,0,           0,0,        0,1, 32'hFFFF,    32'hFFFF,     32'h21};
      mainVecs[17] = '{"issue4_busy",      0, 0, 0, 0, 0,0, 0,0,            1, 4, 0, 0,0,           0,0,        0,0, 32'hFFFF,    32'hFFFF,     32'h21};
      mainVecs[18] = '{"wb4_single",       0, 0, 0, 0, 0,0, 0,0,            0, 4, 1, 4,32'h4,       0,0,        0,0, 32'hFFFF,    32'hFFFF,     32'h21};
      mainVecs[19] = '{"ready4",           1, 4, 0,20, 0,0, 0,0,            0, 4, 0, 0,0,           0,0,        0,1, 32'h4,       32'hFFFF,     32'h21};
      mainVecs[20] = '{"issue21",          0, 0, 0, 0, 0,0, 0,0,            1,21, 0, 0,0,           0,0,        0,1, 32'h4,       32'hFFFF,     32'h21};
      mainVecs[21] = '{"stall_ra21",       1,21, 0, 0, 0,0, 0,0,            0,21, 0, 0,0,           0,0,        1,0, 32'h4,       32'hFFFF,     32'h21};
      mainVecs[22] = '{"wb_other_stall",   1,21, 0, 0, 0,0, 0,0,            0,21, 1,22,32'h22,      0,0,        1,0, 32'h4,       32'hFFFF,     32'h21};
      mainVecs[23] = '{"no_fetch_no_stall",0,21, 0, 0, 0,0, 0,0,            0,21, 0, 0,0,           0,0,        0,0, 32'h4,       32'hFFFF,     32'h21};
      mainVecs[24] = '{"wb21",             1,21,22, 4, 0,0, 0,0,            0,21, 1,21,32'h5151,    0,0,        0,0, 32'h5151,    32'h22,       32'h4};

      zeroVecs[0]  = '{"z_w0_reg0_bypass", 1, 0, 0, 0, 1,1, 0,32'hFFFF,     0, 0, 0, 0,0,           0,0,        0,1, 0,           0,            0};
      zeroVecs[1]  = '{"z_w0_reg1",        1, 0, 1, 0, 1,1, 1,32'hAAAA,     0, 0, 0, 0,0,           0,0,        0,1, 0,           32'hAAAA,     0};
      zeroVecs[2]  = '{"z_issue0_wb0",     0, 0, 0, 0, 0,0, 0,0,            1, 0, 1, 0,32'h77,      0,0,        0,1, 0,           32'hAAAA,     0};
      zeroVecs[3]  = '{"z_fetch0_nostall", 1, 0, 0, 1, 0,0, 0,0,            0, 0, 0, 0,0,           0,0,        0,1, 0,           0,            32'hAAAA};
      zeroVecs[4]  = '{"z_issue1",         0, 0, 0, 0, 0,0, 0,0,            1, 1, 0, 0,0,           0,0,        0,1, 0,           0,            32'hAAAA};
      zeroVecs[5]  = '{"z_stall1",         1, 1, 0, 0, 0,0, 0,0,            0, 1, 0, 0,0,           0,0,        1,0, 0,           0,            32'hAAAA};

      // Power-on reset and the cleared state it leaves behind.
      driveIdle();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      compare("reset.ra", bus.reg_ra_data, 32'h0);
      compare("reset.stall", 32'(bus.fetch_stall), 32'h0);
      compare("reset.ready", 32'(bus.load_issue_ready), 32'h1);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 25; i++) begin
         applyStimulus(mainVecs[i], 1'b0);
         checkOutput(mainVecs[i], 1'b0);
      end

      for (int i = 0; i < 6; i++) begin
         applyStimulus(zeroVecs[i], 1'b1);
         checkOutput(zeroVecs[i], 1'b1);
      end

      // Reset in the middle of operation: reg 3 holds 0x55, load pending on 5.
      v = '{"rst_prep_issue5", 0, 0, 0, 0, 0,0, 0,0, 1, 5, 0, 0,0, 0,0, 0,1, 32'h5151, 32'h22, 32'h4};
      applyStimulus(v, 1'b0);
      checkOutput(v, 1'b0);
      v = '{"rst_prep_fetch3", 1, 3, 7, 9, 0,0, 0,0, 0, 5, 0, 0,0, 0,0, 0,0, 32'h55, 32'hDEADBEEF, 32'h1234};
      applyStimulus(v, 1'b0);
      checkOutput(v, 1'b0);

      @(negedge clock);
      driveIdle();
      bus.enable_reg_fetch = 1'b1;
      bus.reg_rb_addr      = 5'd5;
      bus.load_issue_addr  = 5'd5;
      reset = 1'b1;
      #1;
      compare("midreset.ra", bus.reg_ra_data, 32'h0);
      compare("midreset.rb", bus.reg_rb_data, 32'h0);
      compare("midreset.rt", bus.reg_rt_data, 32'h0);
      compare("midreset.ready5", 32'(bus.load_issue_ready), 32'h1);
      compare("midreset.stall", 32'(bus.fetch_stall), 32'h0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      v = '{"post_reset_fetch3", 1, 3, 5, 7, 0,0, 0,0, 0, 5, 0, 0,0, 0,0, 0,1, 0, 0, 0};
      applyStimulus(v, 1'b0);
      checkOutput(v, 1'b0);

      @(negedge clock);
      driveIdle();
      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
